// File: rtl/veer_ccm_sram_bank_export_if.sv
// rtl/veer_ccm_sram_bank_export_if.sv - exported ICCM/DCCM per-bank memory bus
interface veer_ccm_sram_bank_export_if #(
  parameter int ICCM_NUM_BANKS  = 4,
  parameter int ICCM_BANK_DEPTH = 8192,
  parameter int DCCM_NUM_BANKS  = 4,
  parameter int DCCM_BANK_DEPTH = 8192,
  parameter int DATA_W          = 39
);
  localparam int IAW = $clog2(ICCM_BANK_DEPTH);
  localparam int DAW = $clog2(DCCM_BANK_DEPTH);

  logic [ICCM_NUM_BANKS-1:0]        iccm_clken;
  logic [ICCM_NUM_BANKS-1:0]        iccm_wren_bank;
  logic [ICCM_NUM_BANKS*IAW-1:0]    iccm_addr_bank;
  logic [ICCM_NUM_BANKS*DATA_W-1:0] iccm_bank_wr_data;
  logic [ICCM_NUM_BANKS*DATA_W-1:0] iccm_bank_dout;

  logic [DCCM_NUM_BANKS-1:0]        dccm_clken;
  logic [DCCM_NUM_BANKS-1:0]        dccm_wren_bank;
  logic [DCCM_NUM_BANKS*DAW-1:0]    dccm_addr_bank;
  logic [DCCM_NUM_BANKS*DATA_W-1:0] dccm_wr_data_bank;
  logic [DCCM_NUM_BANKS*DATA_W-1:0] dccm_bank_dout;

  // Core side: drives requests, receives read data
  modport master (
    output iccm_clken, iccm_wren_bank, iccm_addr_bank, iccm_bank_wr_data,
    output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank,
    input  iccm_bank_dout, dccm_bank_dout
  );

  // Memory side: receives requests, returns read data
  modport slave (
    input  iccm_clken, iccm_wren_bank, iccm_addr_bank, iccm_bank_wr_data,
    input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank,
    output iccm_bank_dout, dccm_bank_dout
  );
endinterface

// File: rtl/veer_ccm_sram_bank_export.sv
// rtl/veer_ccm_sram_bank_export.sv - banked single-port SRAM store for ICCM and DCCM
module veer_ccm_sram_bank_export #(
  parameter int ICCM_NUM_BANKS  = 4,
  parameter int ICCM_BANK_DEPTH = 8192,
  parameter int DCCM_NUM_BANKS  = 4,
  parameter int DCCM_BANK_DEPTH = 8192,
  parameter int DATA_W          = 39
) (
  input logic clk,
  input logic rst_b,
  veer_ccm_sram_bank_export_if.slave bus
);
  localparam int IAW = $clog2(ICCM_BANK_DEPTH);
  localparam int DAW = $clog2(DCCM_BANK_DEPTH);

  // ECC bits travel with the data word untouched; nothing here inspects them.
  for (genvar b = 0; b < ICCM_NUM_BANKS; b++) begin : g_iccm
    logic [DATA_W-1:0] mem [ICCM_BANK_DEPTH];
    logic              en;
    logic              we;
    logic [IAW-1:0]    addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] dout;

    assign en    = bus.iccm_clken[b];
    assign we    = bus.iccm_wren_bank[b];
    assign addr  = bus.iccm_addr_bank[b*IAW +: IAW];
    assign wdata = bus.iccm_bank_wr_data[b*DATA_W +: DATA_W];
    assign bus.iccm_bank_dout[b*DATA_W +: DATA_W] = dout;

    // Array write; no reset so contents survive warm reset, blocked while in reset
    always_ff @(posedge clk) begin
      if (rst_b && en && we) mem[addr] <= wdata;
    end

    // Read-first output register: any access returns the old word, idle holds
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)  dout <= '0;
      else if (en) dout <= mem[addr];
    end
  end

  for (genvar b = 0; b < DCCM_NUM_BANKS; b++) begin : g_dccm
    logic [DATA_W-1:0] mem [DCCM_BANK_DEPTH];
    logic              en;
    logic              we;
    logic [DAW-1:0]    addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] dout;

    assign en    = bus.dccm_clken[b];
    assign we    = bus.dccm_wren_bank[b];
    assign addr  = bus.dccm_addr_bank[b*DAW +: DAW];
    assign wdata = bus.dccm_wr_data_bank[b*DATA_W +: DATA_W];
    assign bus.dccm_bank_dout[b*DATA_W +: DATA_W] = dout;

    // Array write; no reset so contents survive warm reset, blocked while in reset
    always_ff @(posedge clk) begin
      if (rst_b && en && we) mem[addr] <= wdata;
    end

    // Read-first output register: any access returns the old word, idle holds
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)  dout <= '0;
      else if (en) dout <= mem[addr];
    end
  end
endmodule

// File: tb/tb_veer_ccm_sram_bank_export.sv
// tb/tb_veer_ccm_sram_bank_export.sv - directed self-checking bench for the CCM SRAM banks
module tb_veer_ccm_sram_bank_export;
  localparam int NB  = 4;
  localparam int DEP = 8192;
  localparam int DW  = 39;
  localparam int AW  = 13;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  veer_ccm_sram_bank_export_if #(
    .ICCM_NUM_BANKS(NB), .ICCM_BANK_DEPTH(DEP),
    .DCCM_NUM_BANKS(NB), .DCCM_BANK_DEPTH(DEP), .DATA_W(DW)
  ) bus ();

  veer_ccm_sram_bank_export #(
    .ICCM_NUM_BANKS(NB), .ICCM_BANK_DEPTH(DEP),
    .DCCM_NUM_BANKS(NB), .DCCM_BANK_DEPTH(DEP), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] idout(input int b);
    return bus.iccm_bank_dout[b*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] ddout(input int b);
    return bus.dccm_bank_dout[b*DW +: DW];
  endfunction

  task automatic idle();
    bus.iccm_clken = '0;
    bus.iccm_wren_bank = '0;
    bus.dccm_clken = '0;
    bus.dccm_wren_bank = '0;
  endtask

  task automatic iacc(input int b, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.iccm_clken[b] = 1'b1;
    bus.iccm_wren_bank[b] = we;
    bus.iccm_addr_bank[b*AW +: AW] = a;
    bus.iccm_bank_wr_data[b*DW +: DW] = d;
  endtask

  task automatic dacc(input int b, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dccm_clken[b] = 1'b1;
    bus.dccm_wren_bank[b] = we;
    bus.dccm_addr_bank[b*AW +: AW] = a;
    bus.dccm_wr_data_bank[b*DW +: DW] = d;
  endtask

  initial begin
    logic [DW-1:0] pv [NB];
    pv[0] = 39'h00_00000000;
    pv[1] = 39'h01_11111111;
    pv[2] = 39'h02_22222222;
    pv[3] = 39'h03_33333333;

    idle();
    bus.iccm_addr_bank = '0;
    bus.iccm_bank_wr_data = '0;
    bus.dccm_addr_bank = '0;
    bus.dccm_wr_data_bank = '0;

    // Reset holds all outputs at zero
    repeat (5) tick();
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("rst_iccm%0d", b), idout(b), '0);
      chk($sformatf("rst_dccm%0d", b), ddout(b), '0);
    end

    // First edge after release with no access keeps zero
    rst_b = 1'b1;
    tick();
    chk("post_rst_idle", idout(0), '0);

    // Basic write then read on ICCM bank 0
    iacc(0, 1'b1, 13'h0010, 39'h7F_DEADBEEF);
    tick();
    idle();
    iacc(0, 1'b0, 13'h0010, '0);
    tick();
    idle();
    chk("basic_rd", idout(0), 39'h7F_DEADBEEF);
    for (int b = 1; b < NB; b++) chk($sformatf("basic_other%0d", b), idout(b), '0);

    // All four DCCM banks written and read in parallel at top address
    for (int b = 0; b < NB; b++) dacc(b, 1'b1, 13'h1FFF, pv[b]);
    tick();
    idle();
    for (int b = 0; b < NB; b++) dacc(b, 1'b0, 13'h1FFF, '0);
    tick();
    idle();
    for (int b = 0; b < NB; b++) chk($sformatf("par_dccm%0d", b), ddout(b), pv[b]);
    chk("par_iccm_untouched", idout(0), 39'h7F_DEADBEEF);

    // Read-first on write, then hold while idle with wren asserted
    iacc(2, 1'b1, 13'd5, 39'h0A_AAAAAAAA);
    tick();
    iacc(2, 1'b1, 13'd5, 39'h05_55555555);
    tick();
    chk("read_first", idout(2), 39'h0A_AAAAAAAA);
    idle();
    bus.iccm_wren_bank[2] = 1'b1;
    bus.iccm_bank_wr_data[2*DW +: DW] = 39'h7F_FFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d", i), idout(2), 39'h0A_AAAAAAAA);
    end
    idle();
    iacc(2, 1'b0, 13'd5, '0);
    tick();
    idle();
    chk("hold_mem", idout(2), 39'h05_55555555);

    // Warm reset: output clears asynchronously, array contents retained
    dacc(2, 1'b1, 13'h0100, 39'h12_3456789A);
    tick();
    idle();
    rst_b = 1'b0;
    #1;
    chk("async_clr_dccm2", ddout(2), '0);
    chk("async_clr_iccm0", idout(0), '0);
    tick();
    tick();
    chk("warm_rst_held", ddout(2), '0);
    rst_b = 1'b1;
    dacc(2, 1'b0, 13'h0100, '0);
    tick();
    idle();
    chk("warm_retain", ddout(2), 39'h12_3456789A);

    // Write coinciding with reset assertion is dropped
    iacc(1, 1'b1, 13'd7, '0);
    tick();
    idle();
    iacc(1, 1'b1, 13'd7, 39'h11_11111111);
    rst_b = 1'b0;
    tick();
    idle();
    chk("rst_wr_dout", idout(1), '0);
    rst_b = 1'b1;
    tick();
    iacc(1, 1'b0, 13'd7, '0);
    tick();
    idle();
    chk("rst_wr_dropped", idout(1), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/veer_ccm_sram_bank_export.md
Name: veer_ccm_sram_bank_export

Overview:
- Behavioural SRAM backing store for the VeeR EL2 core's closely-coupled memories: ICCM (instruction) and DCCM (data).
- Driven by the core's exported memory-interface signals; sits beside the core in the top-level integration.
- Each CCM is split into independent banks.
- Each bank is a single-port, synchronous-read RAM storing 39-bit words (32 data bits plus 7 ECC bits).
- ECC is stored opaquely; this block never computes or checks it.

Parameters:
- ICCM_NUM_BANKS, 4, number of ICCM banks.
- ICCM_BANK_DEPTH, 8192, words per ICCM bank (power of 2).
- DCCM_NUM_BANKS, 4, number of DCCM banks.
- DCCM_BANK_DEPTH, 8192, words per DCCM bank (power of 2).
- DATA_W, 39, bank word width including ECC.

Derived values: IAW = clog2(ICCM_BANK_DEPTH), DAW = clog2(DCCM_BANK_DEPTH).

Ports:
- clk  in  1  memory clock (core clock).
- rst_b  in  1  asynchronous active-low reset.
- iccm_clken  in  ICCM_NUM_BANKS  per-bank access enable.
- iccm_wren_bank  in  ICCM_NUM_BANKS  per-bank write enable (qualified by clken).
- iccm_addr_bank  in  ICCM_NUM_BANKS*IAW  packed per-bank word address; bank b is slice [b*IAW +: IAW].
- iccm_bank_wr_data  in  ICCM_NUM_BANKS*DATA_W  packed per-bank write data.
- iccm_bank_dout  out  ICCM_NUM_BANKS*DATA_W  packed per-bank read data.
- dccm_clken  in  DCCM_NUM_BANKS  per-bank access enable.
- dccm_wren_bank  in  DCCM_NUM_BANKS  per-bank write enable.
- dccm_addr_bank  in  DCCM_NUM_BANKS*DAW  packed per-bank address.
- dccm_wr_data_bank  in  DCCM_NUM_BANKS*DATA_W  packed per-bank write data.
- dccm_bank_dout  out  DCCM_NUM_BANKS*DATA_W  packed per-bank read data.

Behaviour:
- Single clock, clk. Reset rst_b is asynchronous assert, synchronous deassert by the system; this block does not synchronise it.
- Reset values:
  - All dout slices = 0 while rst_b = 0 and on the first edge after release until the next read.
  - Array contents are not cleared by reset; they are retained across warm reset.
  - Contents after power-up are undefined (X in simulation).
- While rst_b = 0, all writes and reads are blocked.
- Each bank is fully independent. All banks of both CCMs may be accessed in the same cycle.
- Write: at posedge clk with clken[b] = 1 and wren[b] = 1, mem_b[addr_b] <= wr_data_b, all DATA_W bits.
- Read:
  - At posedge clk with clken[b] = 1 and wren[b] = 0, dout_b <= mem_b[addr_b].
  - Latency is exactly 1 cycle: data is valid the cycle after the access.
- Write cycle: dout_b <= old content of mem_b[addr_b] (read-first). The written data is visible on a subsequent read.
- Idle: clken[b] = 0 means no access. wren[b] is ignored, dout_b holds its previous value, and addr/data are don't-care.
- Address width exactly matches depth, so there are no out-of-range addresses. Address wrap-around is natural.
- Back-to-back accesses every cycle to the same or different addresses are supported with no bubbles.
- A reset asserted mid-operation immediately zeroes dout. An in-flight write on that same edge is dropped.
- ECC bits [38:32] are stored and returned verbatim. No correction, no error reporting.
- Implementation is inferable RAM, using generate loops over banks, with no vendor primitives.

Test Plan:
- Reset check: hold rst_b = 0, toggle clk 5 cycles -> every iccm_bank_dout and dccm_bank_dout slice reads 0.
- Basic write/read:
  - Write ICCM bank 0 addr 0x0010 = 39'h7F_DEADBEEF.
  - Read next cycle -> dout slice 0 = 39'h7F_DEADBEEF exactly one cycle after the read clken.
  - Other bank slices unchanged.
- Parallel banks:
  - In one cycle, write DCCM banks 0..3 addr 0x1FFF with 39'h00_00000000, 39'h01_11111111, 39'h02_22222222, 39'h03_33333333.
  - Read all four together -> each slice returns its own value. ICCM outputs unaffected.
- Read-first and hold:
  - Mem[5] = 39'h0A_AAAAAAAA; write mem[5] = 39'h05_55555555 -> dout = 39'h0A_AAAAAAAA.
  - Drop clken for 3 cycles with wren = 1 -> dout holds 39'h0A_AAAAAAAA, and mem[5] stays 39'h05_55555555 on a later read.
- Warm reset retention:
  - Write DCCM bank 2 addr 0x0100 = 39'h12_3456789A.
  - Pulse rst_b low for 2 cycles -> dout = 0 during reset.
  - After release, read -> 39'h12_3456789A.
- Reset during write: assert rst_b asynchronously in the same cycle as a write of 39'h11_11111111 to ICCM bank 1 addr 7 (previously 0) -> a post-reset read returns 0.
